nexys_starship_monster_ctrl: RTL and testbench



---
 rtl/nexys_starship_monster_ctrl.sv | 171 +++++++++++++++++
 tb/tb_nexys_starship_monster_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_monster_ctrl.sv
// rtl/nexys_starship_monster_ctrl.sv - multi-station monster controller with global game FSM and LFSR spawns
module nexys_starship_monster_ctrl #(
    parameter int          NUM_STATIONS = 4,
    parameter int          TIMER_W      = 8,
    parameter int          SHOOT_TICKS  = 200,
    parameter logic [15:0] SPAWN_THRESH = 16'h0400,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    tick,
    input  logic                    play,
    input  logic [NUM_STATIONS-1:0] hit,
    input  logic [NUM_STATIONS-1:0] repair,
    output logic [NUM_STATIONS-1:0] monster,
    output logic [NUM_STATIONS-1:0] broken,
    output logic                    game_over,
    output logic                    q_Init,
    output logic                    q_Play,
    output logic                    q_Over,
    output logic [15:0]             score
);

    localparam int RR_W  = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;
    localparam int CNT_W = 4;

    localparam logic [1:0] G_INIT = 2'd0;
    localparam logic [1:0] G_PLAY = 2'd1;
    localparam logic [1:0] G_OVER = 2'd2;

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_FULL   = 2'd1;
    localparam logic [1:0] S_BROKEN = 2'd2;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SHOOT_TICKS - 1);
    localparam logic [RR_W-1:0]    RR_LAST    = RR_W'(NUM_STATIONS - 1);
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11, right-shifting form
    localparam logic [15:0]        LFSR_MASK  = 16'hB400;

    logic [1:0]                                g_q, g_d;
    logic [NUM_STATIONS-1:0][1:0]              st_q, st_d;
    logic [NUM_STATIONS-1:0][TIMER_W-1:0]      timer_q, timer_d;
    logic [15:0]                               score_q, score_d;
    logic [15:0]                               lfsr_q, lfsr_d;
    logic [RR_W-1:0]                           rr_q, rr_d;

    logic                                      all_broken;
    logic                                      spawn_ok;
    logic [CNT_W-1:0]                          hit_cnt;
    logic [16:0]                               score_sum;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            g_q     <= G_INIT;
            st_q    <= '0;
            timer_q <= '0;
            score_q <= '0;
            lfsr_q  <= LFSR_SEED;
            rr_q    <= '0;
        end else begin
            g_q     <= g_d;
            st_q    <= st_d;
            timer_q <= timer_d;
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        all_broken = 1'b1;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            if (st_q[i] != S_BROKEN) begin
                all_broken = 1'b0;
            end
        end
    end

    always_comb begin
        g_d = g_q;
        case (g_q)
            G_INIT:  g_d = play ? G_PLAY : G_INIT;
            G_PLAY:  g_d = all_broken ? G_OVER : G_PLAY;
            G_OVER:  g_d = play ? G_OVER : G_INIT;
            default: g_d = G_INIT;
        endcase
    end

    always_comb begin
        q_Init    = (g_q == G_INIT);
        q_Play    = (g_q == G_PLAY);
        q_Over    = (g_q == G_OVER);
        game_over = (g_q == G_OVER);
        score     = score_q;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            monster[i] = (st_q[i] == S_FULL);
            broken[i]  = (st_q[i] == S_BROKEN);
        end
    end

    assign spawn_ok = (g_q == G_PLAY) && tick && (lfsr_q < SPAWN_THRESH);

    // Station FSMs; the round-robin candidate is the only one allowed to spawn this tick
    always_comb begin
        st_d    = st_q;
        timer_d = timer_q;
        hit_cnt = '0;
        if (g_q == G_PLAY) begin
            for (int i = 0; i < NUM_STATIONS; i++) begin
                case (st_q[i])
                    S_EMPTY: begin
                        if (spawn_ok && (rr_q == RR_W'(i))) begin
                            st_d[i]    = S_FULL;
                            timer_d[i] = '0;
                        end
                    end
                    S_FULL: begin
                        if (hit[i]) begin
                            st_d[i] = S_EMPTY;
                            hit_cnt = hit_cnt + CNT_W'(1);
                        end else if (tick) begin
                            if (timer_q[i] == TIMER_LAST) begin
                                st_d[i]    = S_BROKEN;
                                timer_d[i] = '0;
                            end else begin
                                timer_d[i] = timer_q[i] + TIMER_W'(1);
                            end
                        end
                    end
                    S_BROKEN: begin
                        if (repair[i]) begin
                            st_d[i] = S_EMPTY;
                        end
                    end
                    default: begin
                        st_d[i]    = S_EMPTY;
                        timer_d[i] = '0;
                    end
                endcase
            end
        end else if (g_q != G_OVER) begin
            st_d    = '0;
            timer_d = '0;
        end
    end

    assign score_sum = {1'b0, score_q} + 17'(hit_cnt);

    always_comb begin
        score_d = score_q;
        lfsr_d  = lfsr_q;
        rr_d    = rr_q;
        case (g_q)
            G_PLAY: begin
                score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
                if (tick) begin
                    rr_d = (rr_q == RR_LAST) ? '0 : rr_q + RR_W'(1);
                end
            end
            G_OVER: begin
                score_d = score_q;
            end
            default: begin
                score_d = '0;
                rr_d    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// tb/tb_nexys_starship_monster_ctrl.sv - scoreboard bench for the multi-station monster controller
module tb_nexys_starship_monster_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        tick = 1'b0;
    logic        play = 1'b0;
    logic [3:0]  hit = '0;
    logic [3:0]  repair = '0;
    logic [3:0]  monster;
    logic [3:0]  broken;
    logic        game_over;
    logic        q_Init;
    logic        q_Play;
    logic        q_Over;
    logic [15:0] score;

    int total = 0;
    int bad = 0;

    nexys_starship_monster_ctrl #(
        .NUM_STATIONS(4),
        .TIMER_W(8),
        .SHOOT_TICKS(5),
        .SPAWN_THRESH(16'hFFFF),
        .LFSR_SEED(16'hACE1)
    ) u_dut (
        .Clk(Clk),
        .Reset(Reset),
        .tick(tick),
        .play(play),
        .hit(hit),
        .repair(repair),
        .monster(monster),
        .broken(broken),
        .game_over(game_over),
        .q_Init(q_Init),
        .q_Play(q_Play),
        .q_Over(q_Over),
        .score(score)
    );

    always #5 Clk = ~Clk;

    // Reference model: 0 EMPTY, 1 FULL, 2 BROKEN; global 0 INIT, 1 PLAY, 2 OVER
    int          m_g = 0;
    int          m_st[4];
    int          m_tmr[4];
    int          m_rr = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_score = 0;
    logic [27:0] sb_q[$];

    task automatic model_step(input logic rst, input logic t, input logic [3:0] h, input logic [3:0] r);
        int nst[4];
        int ntm[4];
        int nhits;
        bit allb;
        if (rst) begin
            m_g = 0; m_rr = 0; m_lfsr = 16'hACE1; m_score = 0;
            for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_tmr[i] = 0; end
            return;
        end
        case (m_g)
            0: begin
                for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_tmr[i] = 0; end
                m_score = 0; m_rr = 0;
                m_g = play ? 1 : 0;
            end
            1: begin
                allb = 1;
                nhits = 0;
                for (int i = 0; i < 4; i++) begin
                    if (m_st[i] != 2) allb = 0;
                    nst[i] = m_st[i];
                    ntm[i] = m_tmr[i];
                    if (m_st[i] == 0) begin
                        if (t && m_lfsr < 16'hFFFF && m_rr == i) begin nst[i] = 1; ntm[i] = 0; end
                    end else if (m_st[i] == 1) begin
                        if (h[i]) begin nst[i] = 0; nhits++; end
                        else if (t) begin
                            if (m_tmr[i] == 4) begin nst[i] = 2; ntm[i] = 0; end
                            else ntm[i] = m_tmr[i] + 1;
                        end
                    end else if (r[i]) begin
                        nst[i] = 0;
                    end
                end
                for (int i = 0; i < 4; i++) begin m_st[i] = nst[i]; m_tmr[i] = ntm[i]; end
                m_score = (m_score + nhits > 65535) ? 65535 : m_score + nhits;
                if (t) m_rr = (m_rr + 1) % 4;
                m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
                m_g = allb ? 2 : 1;
            end
            default: m_g = play ? 2 : 0;
        endcase
    endtask

    function automatic logic [27:0] model_out();
        logic [3:0] mo, bo;
        for (int i = 0; i < 4; i++) begin
            mo[i] = (m_st[i] == 1);
            bo[i] = (m_st[i] == 2);
        end
        return {mo, bo, (m_g == 2), (m_g == 0), (m_g == 1), (m_g == 2), 16'(m_score)};
    endfunction

    task automatic cycle(input logic rst, input logic t, input logic [3:0] h, input logic [3:0] r);
        logic [27:0] exp_v;
        logic [27:0] got_v;
        Reset = rst; tick = t; hit = h; repair = r;
        model_step(rst, t, h, r);
        sb_q.push_back(model_out());
        @(posedge Clk);
        #1;
        Reset = 1'b0; tick = 1'b0; hit = '0; repair = '0;
        got_v = {monster, broken, game_over, q_Init, q_Play, q_Over, score};
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got=%h", got_v);
        end else begin
            exp_v = sb_q.pop_front();
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        play = 1'b0;
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, '0, '0);
        total++;
        if ({monster, broken, game_over, score} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {monster, broken, game_over, score});
        end
        total++;
        if ({q_Init, q_Play, q_Over} !== 3'b100) begin
            bad++;
            $display("FAIL reset_state got=%b exp=100", {q_Init, q_Play, q_Over});
        end
    endtask

    task automatic test_start();
        play = 1'b1;
        cycle(1'b0, 1'b0, '0, '0);
        total++;
        if ({q_Init, q_Play, q_Over} !== 3'b010) begin
            bad++;
            $display("FAIL start_play got=%b exp=010", {q_Init, q_Play, q_Over});
        end
    endtask

    task automatic test_spawn_fill();
        logic [3:0] seq [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, '0, '0);
            total++;
            if (monster !== seq[k]) begin
                bad++;
                $display("FAIL spawn_tick%0d got=%b exp=%b", k + 1, monster, seq[k]);
            end
        end
    endtask

    task automatic test_hit();
        cycle(1'b0, 1'b0, 4'b0001, '0);
        total++;
        if ({monster, score} !== {4'b1110, 16'd1}) begin
            bad++;
            $display("FAIL hit_full got=%b/%0d exp=1110/1", monster, score);
        end
        cycle(1'b0, 1'b0, 4'b0001, '0);
        total++;
        if (score !== 16'd1) begin
            bad++;
            $display("FAIL hit_empty got=%0d exp=1", score);
        end
        cycle(1'b0, 1'b0, 4'b1110, '0);
        total++;
        if ({monster, score} !== {4'b0000, 16'd4}) begin
            bad++;
            $display("FAIL hit_multi got=%b/%0d exp=0000/4", monster, score);
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, '0, '0);
        total++;
        if ({monster, broken} !== {4'b1111, 4'b0000}) begin
            bad++;
            $display("FAIL timeout_before got=%b/%b exp=1111/0000", monster, broken);
        end
        cycle(1'b0, 1'b1, '0, '0);
        total++;
        if ({monster, broken} !== {4'b1101, 4'b0010}) begin
            bad++;
            $display("FAIL timeout_break got=%b/%b exp=1101/0010", monster, broken);
        end
        cycle(1'b0, 1'b1, 4'b0100, '0);
        total++;
        if ({monster, broken, score} !== {4'b1001, 4'b0010, 16'd5}) begin
            bad++;
            $display("FAIL hit_beats_expiry got=%b/%b/%0d exp=1001/0010/5", monster, broken, score);
        end
    endtask

    task automatic test_game_over();
        for (int k = 0; k < 25; k++) cycle(1'b0, 1'b1, '0, '0);
        total++;
        if ({game_over, q_Over, broken, monster} !== {1'b1, 1'b1, 4'b1111, 4'b0000}) begin
            bad++;
            $display("FAIL game_over got=%b%b/%b/%b exp=11/1111/0000", game_over, q_Over, broken, monster);
        end
        cycle(1'b0, 1'b0, '0, 4'b1111);
        total++;
        if ({broken, q_Over} !== {4'b1111, 1'b1}) begin
            bad++;
            $display("FAIL repair_in_over got=%b/%b exp=1111/1", broken, q_Over);
        end
        play = 1'b0;
        cycle(1'b0, 1'b0, '0, '0);
        total++;
        if ({q_Init, q_Play, q_Over} !== 3'b100) begin
            bad++;
            $display("FAIL over_to_init got=%b exp=100", {q_Init, q_Play, q_Over});
        end
        cycle(1'b0, 1'b0, '0, '0);
        total++;
        if ({broken, score} !== 20'd0) begin
            bad++;
            $display("FAIL init_clears got=%b/%0d exp=0000/0", broken, score);
        end
    endtask

    task automatic test_reset_midgame();
        play = 1'b1;
        cycle(1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, 4'b0001, '0);
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b1, '0, '0);
        total++;
        if ({monster, score} !== {4'b0110, 16'd1}) begin
            bad++;
            $display("FAIL pre_reset got=%b/%0d exp=0110/1", monster, score);
        end
        cycle(1'b1, 1'b1, 4'b0010, '0);
        total++;
        if ({monster, broken, score, q_Init, game_over} !== {24'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_midgame got=%b/%b/%0d/%b exp=0000/0000/0/1", monster, broken, score, q_Init);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_tmr[i] = 0; end
        test_reset();
        test_start();
        test_spawn_fill();
        test_hit();
        test_timeout();
        test_game_over();
        test_reset_midgame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
